// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg -- shared definitions for the iterative multiplier.
//   mult_state_t : FSM state encoding (IDLE / RUN / FIX)
//   k_legal()    : true for the supported bits-per-cycle values
//   mult_cnt_w() : width of the RUN step counter for a given WIDTH/K
//   MULT_CNT_W, RES_W : counter and result widths for the default geometry
// -----------------------------------------------------------------------------
package mult_pkg;

   localparam int MULT_WIDTH_DEF = 32;
   localparam int MULT_K_DEF     = 2;
   localparam int MULT_CNT_W     = $clog2(MULT_WIDTH_DEF / MULT_K_DEF);
   localparam int RES_W          = 2 * MULT_WIDTH_DEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } mult_state_t;

   function automatic bit k_legal(input int k);
      return (k == 1) || (k == 2) || (k == 4);
   endfunction

   // A single-step configuration still needs a 1-bit counter.
   function automatic int mult_cnt_w(input int width, input int k);
      return ((width / k) > 1) ? $clog2(width / k) : 1;
   endfunction

endpackage

// File: rtl/mult_iter_if.sv
// -----------------------------------------------------------------------------
// mult_iter_if -- start/busy/done handshake and operand bus of mult_iter.
//   start, mult_signed, acc : request and per-operation mode (sampled in IDLE)
//   a, b                    : multiplicand / multiplier, WIDTH bits
//   acc_in                  : accumulate addend, 2*WIDTH bits
//   busy, done, z           : in-flight flag, one-cycle done pulse, result
// master = requester (controller), slave = the multiplier.
// -----------------------------------------------------------------------------
interface mult_iter_if
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH_DEF
);
   logic                 start;
   logic                 mult_signed;
   logic                 acc;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [2*WIDTH-1:0]   acc_in;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   z;

   modport master (
      output start, mult_signed, acc, a, b, acc_in,
      input  busy, done, z
   );

   modport slave (
      input  start, mult_signed, acc, a, b, acc_in,
      output busy, done, z
   );
endinterface

// File: rtl/mult_pp_step.sv
// -----------------------------------------------------------------------------
// mult_pp_step -- one RUN step of the shift-right multiplier.
//   pp      : current 2*WIDTH partial product
//   mcand   : |a|, WIDTH bits unsigned
//   mbits   : next K multiplier bits (LSB-first)
//   pp_next : partial product after adding mcand*mbits into the upper half
//             and shifting the whole product right by K
// After WIDTH/K steps the register holds the full unsigned product.
// -----------------------------------------------------------------------------
module mult_pp_step #(
   parameter int WIDTH = 32,
   parameter int K     = 2
) (
   input  logic [2*WIDTH-1:0] pp,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [K-1:0]       mbits,
   output logic [2*WIDTH-1:0] pp_next
);
   localparam int SW = WIDTH + K;

   // upper half + mcand*mbits <= (2^WIDTH-1)*2^K, so SW bits never overflow
   logic [SW-1:0]        part;
   logic [SW-1:0]        hi_sum;
   logic [2*WIDTH+K-1:0] wide;

   always_comb begin
      part    = SW'(mcand) * SW'(mbits);
      hi_sum  = part + SW'(pp[2*WIDTH-1:WIDTH]);
      wide    = {hi_sum, pp[WIDTH-1:0]};
      pp_next = wide[2*WIDTH+K-1:K];
   end
endmodule

// File: rtl/mult_iter.sv
// -----------------------------------------------------------------------------
// mult_iter -- iterative WIDTH x WIDTH multiplier with optional accumulate,
// retiring K multiplier bits per cycle (MULT/MULTU/MADD/MADDU).
//   clk : rising-edge clock
//   rst : asynchronous, active-low reset
//   bus : mult_iter_if.slave (start/mult_signed/acc/a/b/acc_in in,
//         busy/done/z out)
// Operands are latched as magnitudes on the accept edge; the sign is applied
// once in FIX together with the accumulate addend. done follows the accept
// edge by WIDTH/K+1 cycles.
// -----------------------------------------------------------------------------
module mult_iter
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH_DEF,
   parameter int K     = MULT_K_DEF
) (
   input  logic       clk,
   input  logic       rst,
   mult_iter_if.slave bus
);
   localparam int               CNT_W    = mult_cnt_w(WIDTH, K);
   localparam int               PROD_W   = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH / K - 1);

   if (!k_legal(K)) begin : g_bad_k
      $error("mult_iter: K must be 1, 2 or 4");
   end
   if ((WIDTH % K) != 0) begin : g_bad_width
      $error("mult_iter: WIDTH must be a multiple of K");
   end

   mult_state_t             state;
   logic [CNT_W-1:0]        cnt;
   logic [WIDTH-1:0]        mcand;
   logic [WIDTH-1:0]        mplier;
   logic                    neg;
   logic                    acc_q;
   logic [PROD_W-1:0]       acc_in_q;
   logic [PROD_W-1:0]       pp;
   logic [PROD_W-1:0]       pp_next;
   logic [PROD_W-1:0]       z_q;
   logic                    done_q;

   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic [WIDTH-1:0]        a_abs;
   logic [WIDTH-1:0]        b_abs;
   logic [PROD_W-1:0]       prod_signed;
   logic [PROD_W-1:0]       z_next;

   // -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is the correct
   // magnitude when read as unsigned, so the most-negative operand needs
   // no special handling.
   always_comb begin
      a_s   = bus.a;
      b_s   = bus.b;
      a_abs = (bus.mult_signed && (a_s < 0)) ? WIDTH'(-a_s) : bus.a;
      b_abs = (bus.mult_signed && (b_s < 0)) ? WIDTH'(-b_s) : bus.b;
   end

   mult_pp_step #(
      .WIDTH (WIDTH),
      .K     (K)
   ) u_pp_step (
      .pp      (pp),
      .mcand   (mcand),
      .mbits   (mplier[K-1:0]),
      .pp_next (pp_next)
   );

   // Sign fix-up and accumulate, both modulo 2^(2*WIDTH).
   always_comb begin
      prod_signed = neg ? PROD_W'(-pp) : pp;
      z_next      = prod_signed + (acc_q ? acc_in_q : '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         neg      <= 1'b0;
         acc_q    <= 1'b0;
         acc_in_q <= '0;
         pp       <= '0;
         z_q      <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  mcand    <= a_abs;
                  mplier   <= b_abs;
                  neg      <= bus.mult_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  acc_q    <= bus.acc;
                  acc_in_q <= bus.acc_in;
                  pp       <= '0;
                  cnt      <= CNT_INIT;
                  state    <= ST_RUN;
               end
            end
            ST_RUN: begin
               pp     <= pp_next;
               mplier <= mplier >> K;
               if (cnt == '0) begin
                  state <= ST_FIX;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_FIX: begin
               z_q    <= z_next;
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = (state != ST_IDLE);
   assign bus.done = done_q;
   assign bus.z    = z_q;
endmodule

// File: doc/mult_iter.md
# mult_iter

Parametrised iterative multiplier that succeeds the fixed 32-bit `MULT` unit. It serves MULT/MULTU and adds multiply-accumulate for MADD/MADDU. Operand width and bits-retired-per-cycle are parameters, and signedness is selected per operation. It sits beside the divider under the multi-cycle `controller`, using the same start/busy handshake, and adds an explicit `done` pulse.

## Interface
- `WIDTH`, default 32: operand width; result is 2·WIDTH. Must be a multiple of `K`.
- `K`, default 2: multiplier bits retired per RUN cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clk` input, 1 bit: clock, rising edge.
- `rst` input, 1 bit: **active-low, asynchronous** reset.
- `start` input, 1 bit: request. Sampled only in IDLE.
- `mult_signed` input, 1 bit: 1 means two's-complement operands; sampled with `start`.
- `acc` input, 1 bit: 1 means add `acc_in` to the product; sampled with `start`.
- `a` input, WIDTH bits: multiplicand.
- `b` input, WIDTH bits: multiplier.
- `acc_in` input, 2·WIDTH bits: accumulate addend (HI:LO).
- `busy` output, 1 bit: operation in flight.
- `done` output, 1 bit: one-cycle pulse; `z` is valid from this cycle.
- `z` output, 2·WIDTH bits: result. Holds its value until the next `done`.

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE with `start`=1 → RUN.
  - RUN with `cnt`=0 → FIX.
  - FIX → IDLE, always.
- Accept edge (IDLE, `start`=1) latches:
  - |a| and |b| as WIDTH-bit unsigned values; abs is applied only when `mult_signed`=1.
  - `neg = mult_signed & (a[MSB] ^ b[MSB])`.
  - `acc` and `acc_in`.
  - Clears the 2·WIDTH-bit partial product; sets `cnt = WIDTH/K − 1`.
- After the accept edge, `a`, `b`, `acc_in`, `mult_signed` and `acc` may change freely without affecting the result.
- Most-negative operand: abs(−2^(WIDTH−1)) = 2^(WIDTH−1) fits in WIDTH unsigned bits. No special case is needed.
- RUN edge:
  - Adds (|a| × next K multiplier bits), shifted into place, to the partial product.
  - Consumes multiplier bits LSB first; decrements `cnt`.
- FIX edge:
  - `z <= (neg ? −P : P) + (acc ? acc_in : 0)`, all modulo 2^(2·WIDTH).
  - Overflow wraps silently; no flag is raised.
  - `done <= 1`.
- `start` while `busy`=1 is ignored and is not queued.
- `start` in the cycle `done`=1 is accepted, because the FSM is already in IDLE.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `busy`=0, `done`=0, `z`=0, `cnt`=0, internal registers=0.
- `busy` = (state ≠ IDLE).
- Latency: for accept edge E0, `done` is high for one cycle after edge E0+WIDTH/K+1.
  - Defaults (WIDTH=32, K=2): 17 cycles.
  - K=1: 33 cycles. K=4: 9 cycles.
- `busy` is high for exactly WIDTH/K+1 cycles and falls in the same cycle `done` rises.
- Maximum throughput: one operation per WIDTH/K+1 cycles.
- Reset asserted mid-operation aborts immediately. After release the block is in IDLE with `z`=0 and emits no `done`.

## Structure
- Shared package `mult_pkg`:
  - State encoding typedef (IDLE/RUN/FIX).
  - Legal-`K` check function.
  - Localparams `MULT_CNT_W = $clog2(WIDTH/K)` and `RES_W = 2·WIDTH`.
- One sub-module, `mult_pp_step`: combinational K-bit × WIDTH partial-product add, parametrised by WIDTH and K, instantiated once in RUN.
- Abs/negate and accumulate logic stay in the top module.

## Test plan
- Signed, defaults: a=0xFFFF3F3F, b=0xFFFF7F7F, `mult_signed`=1 → `z`=0x00000000_60C1A141, `done` 17 cycles after accept. Change `a` and `b` to 0x111 and 0x777 mid-RUN → result unchanged.
- Unsigned, same operands, `mult_signed`=0 → `z`=0xFFFEBEBE_60C1A141. Then back-to-back with `start` held in the `done` cycle, a=0x111, b=0x777 → `z`=0x00000000_0007F5E7.
- Corners, signed:
  - 0x80000000 × 0x80000000 → 0x40000000_00000000.
  - 0xFFFFFFFF × 0x00000001 → 0xFFFFFFFF_FFFFFFFF.
  - 0 × anything → 0.
- Accumulate: `acc`=1, `acc_in`=0x00000000_00000001, a=−1, b=1 signed → `z`=0. With `acc_in`=0xFFFFFFFF_FFFFFFFF, a=b=1 unsigned → `z`=0 (wraps).
- Handshake and reset:
  - `start` pulses during `busy` are ignored: exactly one `done` appears and `z` reflects the first operands.
  - `rst`=0 asserted at RUN cycle 5 → `busy`=0 and `z`=0 asynchronously, with no `done` afterwards.
- Parameter sweep with K ∈ {1,2,4} and WIDTH ∈ {8,32}: 1000 random operations (random `mult_signed` and `acc`) compared against a `$signed`/unsigned reference model. `done` must appear exactly at the cycle given by the latency formula.
